// File: rtl/updown_timer_ctrl.sv
// updown_timer_ctrl: programmable up/down timer sequencer.
// Latches a command (period, dir, prescale, periodic) on start, loads the
// counter, steps it once every prescale+1 RUN cycles and raises tick/pend/ovf
// at terminal count. One-shot commands end in DONE; periodic ones auto-reload.
//
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   start, stop   command strobe / abort strobe (stop has priority)
//   ack           clears pend and ovf
//   period        terminal value P (32 bit)
//   dir           1 = count up 0..P, 0 = count down P..0
//   prescale      K, step every K+1 RUN cycles
//   periodic      1 = auto-reload at terminal, 0 = one-shot
//   cnt           current count
//   busy          high in LOAD or RUN
//   tick          one-cycle pulse at terminal count
//   pend, ovf     sticky event flag / event-while-pending flag
//   state         IDLE=0, LOAD=1, RUN=2, DONE=3
module updown_timer_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stop,
    input  logic        ack,
    input  logic [31:0] period,
    input  logic        dir,
    input  logic [7:0]  prescale,
    input  logic        periodic,
    output logic [31:0] cnt,
    output logic        busy,
    output logic        tick,
    output logic        pend,
    output logic        ovf,
    output logic [1:0]  state
);

    localparam int unsigned CNT_W = 32;
    localparam int unsigned PRE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    typedef struct packed {
        logic [CNT_W-1:0] period;
        logic             dir;
        logic [PRE_W-1:0] prescale;
        logic             periodic;
    } cmd_t;

    state_t           state_q, state_n;
    cmd_t             cmd_q, cmd_n;
    logic [PRE_W-1:0] pre_q, pre_n;
    logic [CNT_W-1:0] cnt_n;
    logic             busy_n, tick_n, pend_n, ovf_n;

    logic [CNT_W-1:0] start_val, term_val;
    logic             en, at_term;

    // Start/terminal values and step enable derived from the latched command
    assign start_val = cmd_q.dir ? CNT_W'(0) : cmd_q.period;
    assign term_val  = cmd_q.dir ? cmd_q.period : CNT_W'(0);
    assign en        = (pre_q == cmd_q.prescale);
    assign at_term   = (cnt == term_val);

    // Next-state, datapath and event-flag logic
    always_comb begin
        state_n = state_q;
        cmd_n   = cmd_q;
        pre_n   = pre_q;
        cnt_n   = cnt;
        tick_n  = 1'b0;
        pend_n  = pend;
        ovf_n   = ovf;

        case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    cmd_n   = '{period, dir, prescale, periodic};
                    state_n = LOAD;
                end
            end
            LOAD: begin
                if (stop) begin
                    state_n = IDLE;
                end else if (start) begin
                    cmd_n   = '{period, dir, prescale, periodic};
                    state_n = LOAD;
                end else begin
                    cnt_n   = start_val;
                    pre_n   = PRE_W'(0);
                    state_n = RUN;
                end
            end
            RUN: begin
                if (stop) begin
                    state_n = IDLE;
                end else if (start) begin
                    cmd_n   = '{period, dir, prescale, periodic};
                    state_n = LOAD;
                end else if (en) begin
                    pre_n = PRE_W'(0);
                    if (!at_term) begin
                        cnt_n = cmd_q.dir ? cnt + CNT_W'(1) : cnt - CNT_W'(1);
                    end else begin
                        tick_n = 1'b1;
                        if (cmd_q.periodic) begin
                            cnt_n = start_val;
                        end else begin
                            state_n = DONE;
                        end
                    end
                end else begin
                    pre_n = pre_q + PRE_W'(1);
                end
            end
            DONE: begin
                if (stop) begin
                    state_n = IDLE;
                end else if (start) begin
                    cmd_n   = '{period, dir, prescale, periodic};
                    state_n = LOAD;
                end else if (ack) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

        // A tick on the ack edge wins: pend stays set and ovf is left alone
        if (tick_n) begin
            pend_n = 1'b1;
            if (pend && !ack) begin
                ovf_n = 1'b1;
            end
        end else if (ack) begin
            pend_n = 1'b0;
            ovf_n  = 1'b0;
        end

        busy_n = (state_n == LOAD) || (state_n == RUN);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cmd_q   <= '0;
            pre_q   <= '0;
            cnt     <= '0;
            busy    <= 1'b0;
            tick    <= 1'b0;
            pend    <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            state_q <= state_n;
            cmd_q   <= cmd_n;
            pre_q   <= pre_n;
            cnt     <= cnt_n;
            busy    <= busy_n;
            tick    <= tick_n;
            pend    <= pend_n;
            ovf     <= ovf_n;
        end
    end

    assign state = state_q;

endmodule
